// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
// In-order request/grant fetches with arbitrary response latency; a taken branch flushes the queue.
module if_prefetch_queue #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branchTaken,
    input  logic [ADDR_W-1:0]      branchAddress,
    input  logic                   hazard,
    output logic                   imemReq,
    output logic [ADDR_W-1:0]      imemAddr,
    input  logic                   imemGnt,
    input  logic                   imemRvalid,
    input  logic [INST_W-1:0]      imemRdata,
    output logic                   instValid,
    output logic [INST_W-1:0]      inst,
    output logic [ADDR_W-1:0]      pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int           PW   = $clog2(DEPTH);
    localparam int           CW   = PW + 1;
    localparam logic [CW:0]  FULL = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;
    logic [PW-1:0]     head_q, tail_q, fill_q;
    logic [CW-1:0]     count_q;   // allocated entries
    logic [CW-1:0]     pend_q;    // allocated but not yet filled
    logic [CW-1:0]     drop_q;    // responses owed to flushed requests
    logic [CW:0]       owed;
    logic              grant, pop, resp_fill, resp_drop;

    // Credit counts both live slots and stale responses so every response lands somewhere.
    assign owed      = {1'b0, drop_q} + {1'b0, pend_q};
    assign imemReq   = !rst && !branchTaken && (({1'b0, count_q} + {1'b0, drop_q}) < FULL);
    assign imemAddr  = fetch_pc;
    assign grant     = imemReq && imemGnt;
    assign instValid = (count_q != '0) && filled_q[head_q];
    assign pop       = instValid && !hazard && !branchTaken;
    assign resp_drop = imemRvalid && (drop_q != '0);
    assign resp_fill = imemRvalid && (drop_q == '0) && (pend_q != '0) && !branchTaken;

    assign inst  = instValid ? inst_q[head_q] : '0;
    assign pc    = instValid ? addr_q[head_q] + ADDR_W'(PC_STEP) : '0;
    assign count = count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            drop_q   <= '0;
        end else if (branchTaken) begin
            // A response arriving in the flush cycle settles one of the owed requests.
            fetch_pc <= branchAddress;
            head_q   <= tail_q;
            fill_q   <= tail_q;
            count_q  <= '0;
            pend_q   <= '0;
            drop_q   <= (imemRvalid && owed != '0) ? CW'(owed - 1'b1) : CW'(owed);
        end else begin
            if (grant) begin
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + 1'b1;
                fetch_pc         <= fetch_pc + ADDR_W'(PC_STEP);
            end
            if (resp_fill) begin
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + 1'b1;
            end
            if (resp_drop)
                drop_q <= drop_q - 1'b1;
            if (pop)
                head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(grant) - CW'(pop);
            pend_q  <= pend_q + CW'(grant) - CW'(resp_fill);
        end
    end

    // NOTE: the payload storage is not reset; filled flags and count gate everything read from it.
    always_ff @(posedge clk) begin
        if (grant)
            addr_q[tail_q] <= fetch_pc;
        if (resp_fill)
            inst_q[fill_q] <= imemRdata;
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: in-order memory model with programmable latency,
// sequential pc/inst tracking for every consumed instruction, plus hand-computed step checks.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst, branchTaken, hazard, imemGnt, imemRvalid;
    logic [31:0] branchAddress, imemRdata;
    logic        imemReq, instValid;
    logic [31:0] imemAddr, inst, pc;
    logic [2:0]  count;

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .ADDR_W(32), .INST_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .branchTaken(branchTaken), .branchAddress(branchAddress),
        .hazard(hazard), .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
        .imemRvalid(imemRvalid), .imemRdata(imemRdata), .instValid(instValid),
        .inst(inst), .pc(pc), .count(count)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          lat    = 1;
    logic [31:0] exp_pc = 32'h4;
    logic [31:0] q_addr [$];
    int          q_cyc  [$];
    logic        req_s;
    logic [31:0] addr_s;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE5A0_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive this cycle's response, settle, and check whatever decode sees at the head.
    task automatic cycle_begin();
        imemRvalid = 1'b0;
        imemRdata  = '0;
        if (q_addr.size() > 0 && cyc >= q_cyc[0] + lat) begin
            imemRvalid = 1'b1;
            imemRdata  = mem_word(q_addr[0]);
        end
        #1;
        req_s  = imemReq;
        addr_s = imemAddr;
        if (instValid) begin
            check("track_pc", pc, exp_pc);
            check("track_inst", inst, mem_word(exp_pc - 32'd4));
            if (!hazard && !branchTaken)
                exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic cycle_end();
        @(posedge clk);
        if (imemRvalid) begin
            q_addr.delete(0);
            q_cyc.delete(0);
        end
        if (req_s && imemGnt) begin
            q_addr.push_back(addr_s);
            q_cyc.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        cycle_begin();
        cycle_end();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imemRvalid = 1'b0;
        q_addr.delete();
        q_cyc.delete();
        exp_pc = 32'h4;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; branchTaken = 1'b0; branchAddress = '0; hazard = 1'b0;
        imemGnt = 1'b1; imemRvalid = 1'b0; imemRdata = '0;
        #2;
        check("rst_req", imemReq, 0);
        check("rst_addr", imemAddr, 0);
        check("rst_valid", instValid, 0);
        check("rst_inst", inst, 0);
        check("rst_pc", pc, 0);
        check("rst_count", count, 0);
        check("rst_drop", dut.drop_q, 0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming at L=1: one fetch and one decode per cycle from cycle 2
        for (int i = 0; i < 8; i++) begin
            cycle_begin();
            check("seq_req", imemReq, 1);
            check("seq_addr", imemAddr, 32'(4 * i));
            check("seq_valid", instValid, (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 3) check("seq_count", count, 2);
            cycle_end();
        end

        // Decode stall: queue fills to DEPTH and requests stop, head frozen at pc=28
        hazard = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle_begin();
            check("hz_pc", pc, 32'd28);
            check("hz_count", count, (i == 0) ? 32'd2 : (i == 1) ? 32'd3 : 32'd4);
            check("hz_req", imemReq, (i < 2) ? 32'd1 : 32'd0);
            cycle_end();
        end
        hazard = 1'b0;
        cycle_begin();
        check("rel_count", count, 4);
        check("rel_req", imemReq, 0);
        cycle_end();
        cycle_begin();
        check("rel_req2", imemReq, 1);
        cycle_end();
        for (int i = 0; i < 4; i++) step();
        check("rel_exp_pc", exp_pc, 32'd52);

        // Asynchronous reset with three entries allocated
        cycle_begin();
        check("pre_rst_count", count, 3);
        rst = 1'b1;
        #1;
        check("async_valid", instValid, 0);
        check("async_count", count, 0);
        check("async_req", imemReq, 0);
        lat = 3;
        apply_reset();

        // Flush with two requests in flight (L=3)
        cycle_begin();
        check("restart_addr", imemAddr, 0);
        check("restart_req", imemReq, 1);
        cycle_end();
        step();
        branchTaken = 1'b1; branchAddress = 32'h100;
        cycle_begin();
        check("br_req", imemReq, 0);
        check("br_count_pre", count, 2);
        cycle_end();
        branchTaken = 1'b0; exp_pc = 32'h104;
        cycle_begin();
        check("br_valid", instValid, 0);
        check("br_count", count, 0);
        check("br_drop2", dut.drop_q, 2);
        check("br_req_resume", imemReq, 1);
        check("br_addr", imemAddr, 32'h100);
        cycle_end();
        cycle_begin();
        check("br_drop1", dut.drop_q, 1);
        check("br_addr2", imemAddr, 32'h104);
        cycle_end();
        cycle_begin();
        check("br_drop0", dut.drop_q, 0);
        cycle_end();
        cycle_begin();
        check("br_valid_late", instValid, 0);
        cycle_end();
        cycle_begin();
        check("br_first_valid", instValid, 1);
        check("br_first_pc", pc, 32'h104);
        check("br_first_inst", inst, mem_word(32'h100));
        check("br_full_req", imemReq, 0);
        cycle_end();

        // L=2: simultaneous pop/grant/response, flush colliding with a response, address wrap
        lat = 2;
        apply_reset();
        step(); step(); step();
        cycle_begin();
        check("pgr_count_a", count, 3);
        check("pgr_valid", instValid, 1);
        cycle_end();
        cycle_begin();
        check("pgr_count_b", count, 3);
        cycle_end();
        branchTaken = 1'b1; branchAddress = 32'hFFFF_FFFC;
        cycle_begin();
        check("col_drop_pre", dut.drop_q, 0);
        cycle_end();
        branchTaken = 1'b0; exp_pc = 32'h0;
        cycle_begin();
        check("col_drop", dut.drop_q, 1);
        check("col_count", count, 0);
        check("col_valid", instValid, 0);
        check("wrap_addr0", imemAddr, 32'hFFFF_FFFC);
        check("col_req", imemReq, 1);
        cycle_end();
        cycle_begin();
        check("wrap_addr1", imemAddr, 32'h0);
        check("col_drop_done", dut.drop_q, 0);
        cycle_end();
        step();
        cycle_begin();
        check("wrap_valid", instValid, 1);
        check("wrap_pc", pc, 32'h0);
        check("wrap_inst", inst, mem_word(32'hFFFF_FFFC));
        cycle_end();

        // Back-to-back branches: the last target wins
        branchTaken = 1'b1; branchAddress = 32'h200;
        step();
        branchAddress = 32'h300;
        cycle_begin();
        check("b2b_drop", dut.drop_q, 1);
        check("b2b_valid", instValid, 0);
        check("b2b_req", imemReq, 0);
        cycle_end();
        branchTaken = 1'b0; exp_pc = 32'h304;
        cycle_begin();
        check("b2b_addr", imemAddr, 32'h300);
        check("b2b_drop0", dut.drop_q, 0);
        check("b2b_count", count, 0);
        cycle_end();
        step(); step();
        cycle_begin();
        check("b2b_valid_pc", pc, 32'h304);
        check("b2b_valid_inst", inst, mem_word(32'h300));
        cycle_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Parametrised instruction-fetch stage for the ARM pipeline with a DEPTH-entry prefetch queue between instruction memory and decode. It issues in-order fetch requests over a request/grant, response-valid memory interface with arbitrary latency. Decode stalls through `hazard`. A taken branch flushes queued instructions and discards in-flight responses. It replaces the fixed single-register IF stage in front of the IF/ID register.

## Interface
- ADDR_W, 32, address and PC width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- PC_STEP, 4, fetch address increment
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- branchTaken  in  1  redirect fetch to branchAddress and flush
- branchAddress  in  ADDR_W  redirect target
- hazard  in  1  decode stall; the head entry is not consumed
- imemReq  out  1  fetch request valid
- imemAddr  out  ADDR_W  fetch address (= fetchPc)
- imemGnt  in  1  request accepted this cycle; only meaningful with imemReq
- imemRvalid  in  1  response valid; responses return in request order
- imemRdata  in  INST_W  response instruction
- instValid  out  1  head entry holds a filled instruction
- inst  out  INST_W  head instruction; 0 when instValid=0
- pc  out  ADDR_W  head address + PC_STEP; 0 when instValid=0
- count  out  clog2(DEPTH)+1  allocated entries, filled and unfilled

## Operation
- State:
  - fetchPc
  - circular queue of DEPTH entries {addr, inst, filled}
  - head, tail and fill pointers
  - dropCnt: responses still owed for flushed requests
- Request: `imemReq = !rst && !branchTaken && (count + dropCnt < DEPTH)`. This signal is combinational; credit guarantees every response has a slot.
- Grant (imemReq && imemGnt):
  - allocate the tail entry with addr=fetchPc, filled=0
  - tail++
  - `fetchPc += PC_STEP`, modulo 2^ADDR_W; wraps from all-ones region to low addresses
- Response (imemRvalid):
  - if dropCnt>0: discard, dropCnt--
  - else: write imemRdata into the entry at the fill pointer, set filled, fill++
  - a response with no allocated unfilled entry and dropCnt=0 is a protocol error and is ignored
- Pop: `instValid && !hazard && !branchTaken` frees the head; head++.
- Pop, grant and response may all occur in the same cycle. count changes by +grant −pop. DEPTH entries all allocated → count=DEPTH, imemReq=0 until a pop.
- Flush (branchTaken=1), which wins over all other events:
  - all entries are freed; head=tail=fill; count=0
  - fetchPc ← branchAddress
  - dropCnt ← dropCnt + (allocated unfilled entries) − (imemRvalid this cycle). A response arriving in the flush cycle is discarded.
  - no pop, no grant
- Fetching resumes the next cycle at branchAddress, even while dropCnt>0, within the credit.
- Back-to-back branchTaken: each cycle re-flushes; the last branchAddress wins.
- Reset: asynchronously clears all state. Instruction memory must be reset together; responses to pre-reset requests are undefined.

## Timing
- Reset values: imemReq=0, imemAddr=RESET_PC, instValid=0, inst=0, pc=0, count=0, dropCnt=0.
- First request in the first cycle with rst low.
- Latency:
  - memory returning imemRvalid L cycles after grant → instValid rises L+1 cycles after grant (fill registered)
  - minimum grant-to-decode is 2 cycles at L=1
- Throughput of 1 instruction/cycle sustained when DEPTH ≥ L+2 and hazard=0.
- Flush: instValid=0 in the cycle after branchTaken. The earliest redirected instruction is valid L+2 cycles after branchTaken when dropCnt=0.
- hazard holds inst/pc stable. Requests continue until count+dropCnt=DEPTH.

## Test plan
- Reset, gnt always 1, L=1, hazard=0:
  - imemAddr 0,4,8,… on consecutive cycles
  - instValid from cycle 2
  - pc 4,8,12,… one per cycle, inst matching memory
- hazard held high 10 cycles (DEPTH=4, L=1):
  - count saturates at 4, imemReq=0
  - inst/pc frozen
  - on release, no instruction is lost or duplicated
- branchTaken with branchAddress=0x100 while 2 requests are in flight:
  - dropCnt=2; both stale responses discarded
  - next fetch at 0x100; first valid pc=0x104
- Simultaneous imemRvalid and branchTaken: that response discarded, dropCnt reflects only the remaining in-flight requests; pop, grant and response in one cycle leave count unchanged.
- fetchPc=0xFFFFFFFC, ADDR_W=32: next imemAddr=0x00000000; the pc output wraps likewise.
- rst asserted mid-stream with count=3: instValid, count and imemReq drop to 0 immediately without a clock edge; after release, fetch restarts at RESET_PC.
